// File: rtl/upload_arbiter_pkg.sv
// Shared definitions for the upload arbiter.
//   - source-index constants for the upload handlers
//   - source-ID byte values the handlers stamp on their upload bytes
//   - arbiter state encoding
//   - watchdog counter width
package upload_arbiter_pkg;

    localparam int SRC_UART = 0;
    localparam int SRC_SPI  = 1;

    localparam logic [7:0] UPLOAD_ID_UART = 8'h75;
    localparam logic [7:0] UPLOAD_ID_SPI  = 8'h73;

    localparam int WDOG_W = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/upload_arbiter_rr_picker.sv
// rr_picker: combinational round-robin find-first.
// Ports:
//   req   in  NUM_SRC : request vector
//   start in  IDX_W   : index searched first; the search wraps past NUM_SRC-1 to 0
//   idx   out IDX_W   : first requesting index found from start (0 when none)
//   found out 1       : at least one request is set
module rr_picker #(
    parameter int NUM_SRC = 2,
    localparam int IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   start,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Walk from the farthest offset back to offset 0 so the closest
    // requester to start is the last assignment and wins.
    always_comb begin
        idx      = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            cand     = (int'(start) + k) % NUM_SRC;
            cand_idx = IDX_W'(cand);
            if (req[cand_idx]) begin
                idx   = cand_idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/upload_arbiter.sv
// upload_arbiter: merges per-handler upload streams onto the single upload bus
// of the command processor. One source owns the bus for a whole packet;
// sources are served round-robin and a stalled owner is released by a watchdog.
// Ports:
//   clk, rst                  : system clock, async active-high reset
//   src_req/valid  [NUM_SRC]  : per-source packet request and byte valid
//   src_data/source[8*NUM_SRC]: per-source byte and source-ID, source i at [8i+7:8i]
//   src_ready      [NUM_SRC]  : per-source byte accept
//   merged_*                  : single upload bus towards the processor
//   grant_idx                 : current or last granted source
//   timeout_pulse             : one cycle high when the watchdog forces a release
module upload_arbiter
    import upload_arbiter_pkg::*;
#(
    parameter int NUM_SRC     = 2,
    parameter int TIMEOUT_CYC = 65535,
    localparam int IDX_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SRC-1:0]   src_req,
    input  logic [NUM_SRC*8-1:0] src_data,
    input  logic [NUM_SRC*8-1:0] src_source,
    input  logic [NUM_SRC-1:0]   src_valid,
    output logic [NUM_SRC-1:0]   src_ready,
    output logic                 merged_req,
    output logic [7:0]           merged_data,
    output logic [7:0]           merged_source,
    output logic                 merged_valid,
    input  logic                 merged_ready,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 timeout_pulse
);

    arb_state_t        state, state_nxt;
    logic [IDX_W-1:0]  grant_q;
    logic [IDX_W-1:0]  last_q;
    logic [IDX_W-1:0]  start_idx;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_found;
    logic [WDOG_W-1:0] wdog_q;

    logic req_g;
    logic valid_g;
    logic xfer;
    logic pending;
    logic timeout_hit;

    assign start_idx = (last_q == IDX_W'(NUM_SRC - 1)) ? '0 : last_q + IDX_W'(1);

    rr_picker #(
        .NUM_SRC (NUM_SRC)
    ) u_picker (
        .req   (src_req),
        .start (start_idx),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign req_g       = src_req[grant_q];
    assign valid_g     = src_valid[grant_q];
    assign xfer        = valid_g & merged_ready;
    assign pending     = valid_g & ~merged_ready;
    assign timeout_hit = (wdog_q >= WDOG_W'(TIMEOUT_CYC));
    assign grant_idx   = grant_q;

    always_comb begin
        state_nxt     = state;
        merged_req    = 1'b0;
        merged_data   = 8'h00;
        merged_source = 8'h00;
        merged_valid  = 1'b0;
        src_ready     = '0;
        timeout_pulse = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                merged_req         = 1'b1;
                merged_data        = src_data[8*grant_q +: 8];
                merged_source      = src_source[8*grant_q +: 8];
                merged_valid       = valid_g;
                src_ready[grant_q] = merged_ready;
                timeout_pulse      = timeout_hit;
                // A byte accepted in the same cycle req falls is complete,
                // so only a still-pending byte holds the grant.
                if (timeout_hit || (!req_g && !pending)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_SRC - 1);
            wdog_q  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    wdog_q <= '0;
                    if (pick_found) begin
                        grant_q <= pick_idx;
                    end
                end
                ST_GRANT: begin
                    if (xfer) begin
                        wdog_q <= '0;
                    end else if (wdog_q != '1) begin
                        wdog_q <= wdog_q + WDOG_W'(1);
                    end
                    if (state_nxt == ST_IDLE) begin
                        last_q <= grant_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_upload_arbiter.sv
module tb_upload_arbiter;
    import upload_arbiter_pkg::*;

    localparam int NUM_SRC = 2;
    localparam int TMO     = 8;

    logic                 clk;
    logic                 rst;
    logic [NUM_SRC-1:0]   src_req;
    logic [NUM_SRC*8-1:0] src_data;
    logic [NUM_SRC*8-1:0] src_source;
    logic [NUM_SRC-1:0]   src_valid;
    logic [NUM_SRC-1:0]   src_ready;
    logic                 merged_req;
    logic [7:0]           merged_data;
    logic [7:0]           merged_source;
    logic                 merged_valid;
    logic                 merged_ready;
    logic [0:0]           grant_idx;
    logic                 timeout_pulse;

    upload_arbiter #(
        .NUM_SRC     (NUM_SRC),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .src_req       (src_req),
        .src_data      (src_data),
        .src_source    (src_source),
        .src_valid     (src_valid),
        .src_ready     (src_ready),
        .merged_req    (merged_req),
        .merged_data   (merged_data),
        .merged_source (merged_source),
        .merged_valid  (merged_valid),
        .merged_ready  (merged_ready),
        .grant_idx     (grant_idx),
        .timeout_pulse (timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] req;
        logic [1:0] valid;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       mrdy;
        logic       e_req;
        logic       e_valid;
        logic [7:0] e_data;
        logic [7:0] e_src;
        logic [1:0] e_rdy;
        logic       e_gidx;
        logic       e_to;
    } vec_t;

    vec_t vt[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [1:0] req, input logic [1:0] valid,
                                input logic [7:0] d0, input logic [7:0] d1, input logic mrdy,
                                input logic e_req, input logic e_valid, input logic [7:0] e_data,
                                input logic [7:0] e_src, input logic [1:0] e_rdy,
                                input logic e_gidx, input logic e_to);
        vec_t v;
        v.req = req; v.valid = valid; v.d0 = d0; v.d1 = d1; v.mrdy = mrdy;
        v.e_req = e_req; v.e_valid = e_valid; v.e_data = e_data; v.e_src = e_src;
        v.e_rdy = e_rdy; v.e_gidx = e_gidx; v.e_to = e_to;
        return v;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic e_req, input logic e_valid,
                           input logic [7:0] e_data, input logic [7:0] e_src,
                           input logic [1:0] e_rdy, input logic e_gidx, input logic e_to);
        chk({tag, "_req"},   merged_req,    e_req);
        chk({tag, "_valid"}, merged_valid,  e_valid);
        chk({tag, "_data"},  merged_data,   e_data);
        chk({tag, "_src"},   merged_source, e_src);
        chk({tag, "_rdy"},   src_ready,     e_rdy);
        chk({tag, "_gidx"},  grant_idx,     e_gidx);
        chk({tag, "_to"},    timeout_pulse, e_to);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] U;
        logic [7:0] S;
        U = UPLOAD_ID_UART;
        S = UPLOAD_ID_SPI;

        // single SPI packet
        vt.push_back(mk(2'b10, 2'b00, 8'h00, 8'h00, 1'b1, 0, 0, 8'h00, 8'h00, 2'b00, 0, 0));
        vt.push_back(mk(2'b10, 2'b10, 8'h00, 8'h11, 1'b1, 1, 1, 8'h11, S, 2'b10, 1, 0));
        vt.push_back(mk(2'b10, 2'b10, 8'h00, 8'h12, 1'b1, 1, 1, 8'h12, S, 2'b10, 1, 0));
        vt.push_back(mk(2'b10, 2'b10, 8'h00, 8'h13, 1'b1, 1, 1, 8'h13, S, 2'b10, 1, 0));
        vt.push_back(mk(2'b10, 2'b10, 8'h00, 8'h14, 1'b1, 1, 1, 8'h14, S, 2'b10, 1, 0));
        vt.push_back(mk(2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 1, 0, 8'h00, S, 2'b10, 1, 0));
        vt.push_back(mk(2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 0, 0, 8'h00, 8'h00, 2'b00, 1, 0));
        // both request: UART (last was SPI), then SPI (last was UART)
        vt.push_back(mk(2'b11, 2'b00, 8'h00, 8'h00, 1'b1, 0, 0, 8'h00, 8'h00, 2'b00, 1, 0));
        vt.push_back(mk(2'b11, 2'b01, 8'hA1, 8'h00, 1'b1, 1, 1, 8'hA1, U, 2'b01, 0, 0));
        vt.push_back(mk(2'b10, 2'b00, 8'h00, 8'h00, 1'b1, 1, 0, 8'h00, U, 2'b01, 0, 0));
        vt.push_back(mk(2'b11, 2'b00, 8'h00, 8'h00, 1'b1, 0, 0, 8'h00, 8'h00, 2'b00, 0, 0));
        vt.push_back(mk(2'b11, 2'b10, 8'h00, 8'hB1, 1'b1, 1, 1, 8'hB1, S, 2'b10, 1, 0));
        vt.push_back(mk(2'b01, 2'b00, 8'h00, 8'h00, 1'b1, 1, 0, 8'h00, S, 2'b10, 1, 0));
        vt.push_back(mk(2'b01, 2'b00, 8'h00, 8'h00, 1'b1, 0, 0, 8'h00, 8'h00, 2'b00, 1, 0));
        // UART packet with backpressure; SPI requests/valid ignored meanwhile
        vt.push_back(mk(2'b01, 2'b01, 8'hC1, 8'h00, 1'b1, 1, 1, 8'hC1, U, 2'b01, 0, 0));
        vt.push_back(mk(2'b11, 2'b11, 8'hC2, 8'hEE, 1'b0, 1, 1, 8'hC2, U, 2'b00, 0, 0));
        vt.push_back(mk(2'b11, 2'b11, 8'hC2, 8'hEE, 1'b0, 1, 1, 8'hC2, U, 2'b00, 0, 0));
        vt.push_back(mk(2'b11, 2'b11, 8'hC2, 8'hEE, 1'b1, 1, 1, 8'hC2, U, 2'b01, 0, 0));
        // req falls with byte pending: grant held until accepted
        vt.push_back(mk(2'b00, 2'b01, 8'hC3, 8'h00, 1'b0, 1, 1, 8'hC3, U, 2'b00, 0, 0));
        vt.push_back(mk(2'b00, 2'b01, 8'hC3, 8'h00, 1'b1, 1, 1, 8'hC3, U, 2'b01, 0, 0));
        vt.push_back(mk(2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 0, 0, 8'h00, 8'h00, 2'b00, 0, 0));

        rst          = 1'b1;
        src_req      = '0;
        src_valid    = '0;
        src_data     = '0;
        src_source   = {UPLOAD_ID_SPI, UPLOAD_ID_UART};
        merged_ready = 1'b0;
        #3;
        chk_all("reset", 0, 0, 8'h00, 8'h00, 2'b00, 0, 0);
        #9 rst = 1'b0;
        next_cycle();

        foreach (vt[i]) begin
            src_req      = vt[i].req;
            src_valid    = vt[i].valid;
            src_data     = {vt[i].d1, vt[i].d0};
            merged_ready = vt[i].mrdy;
            #4;
            chk_all($sformatf("row%0d", i), vt[i].e_req, vt[i].e_valid, vt[i].e_data,
                    vt[i].e_src, vt[i].e_rdy, vt[i].e_gidx, vt[i].e_to);
            next_cycle();
        end

        // watchdog: SPI wins (last = UART) and never sends a byte
        src_req = 2'b11; src_valid = 2'b00; src_data = '0; merged_ready = 1'b1;
        #4;
        chk("wd_idle_req", merged_req, 1'b0);
        next_cycle();
        for (int k = 1; k <= TMO + 1; k++) begin
            #4;
            chk($sformatf("wd_g%0d_req", k), merged_req, 1'b1);
            chk($sformatf("wd_g%0d_gidx", k), grant_idx, 1'b1);
            chk($sformatf("wd_g%0d_to", k), timeout_pulse, (k == TMO + 1) ? 1'b1 : 1'b0);
            next_cycle();
        end
        #4;
        chk("wd_after_req", merged_req, 1'b0);
        chk("wd_after_to", timeout_pulse, 1'b0);
        next_cycle();
        src_req = 2'b00;
        #4;
        chk("wd_uart_req", merged_req, 1'b1);
        chk("wd_uart_gidx", grant_idx, 1'b0);
        next_cycle();

        // reset in the middle of a UART packet
        src_req = 2'b01;
        #4;
        chk("rp_idle_req", merged_req, 1'b0);
        next_cycle();
        src_valid = 2'b01; src_data = {8'h00, 8'hD1};
        #4;
        chk("rp_b1_data", merged_data, 8'hD1);
        next_cycle();
        src_data = {8'h00, 8'hD2};
        #4;
        chk("rp_b2_data", merged_data, 8'hD2);
        next_cycle();
        src_data = {8'h00, 8'hD3};
        #2 rst = 1'b1;
        #1;
        chk_all("rp_rst", 0, 0, 8'h00, 8'h00, 2'b00, 0, 0);
        @(posedge clk);
        #3;
        src_req = 2'b11; src_valid = 2'b00;
        rst = 1'b0;
        #1;
        chk("rp_post_req", merged_req, 1'b0);
        next_cycle();
        #4;
        chk("rp_regrant_req", merged_req, 1'b1);
        chk("rp_regrant_gidx", grant_idx, 1'b0);
        chk("rp_regrant_src", merged_source, UPLOAD_ID_UART);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/upload_arbiter.md
# upload_arbiter

Merges the per-handler upload streams (UART, SPI, and later handlers) into the single upload bus consumed by `command_processor`. It replaces the hard-wired single-source connection in the top level. The block grants one handler at a time for a whole packet, with round-robin fairness. A stalled handler is force-released by a watchdog.

## Interface
Parameters:
- `NUM_SRC`, 2: number of upload sources; index 0 = UART, 1 = SPI.
- `TIMEOUT_CYC`, 65535: granted cycles without a byte transfer before forced release; must be ≥ 2.

Ports (clock and reset first):
- `clk` in 1: system clock; the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `src_req` in NUM_SRC: per-source packet request, level, held for the whole packet.
- `src_data` in NUM_SRC*8: per-source byte; source i occupies bits [8i+7:8i].
- `src_source` in NUM_SRC*8: per-source source-ID byte, same packing.
- `src_valid` in NUM_SRC: per-source byte valid.
- `src_ready` out NUM_SRC: per-source byte accept.
- `merged_req` out 1: to the processor's `upload_req_in`.
- `merged_data` out 8: to `upload_data_in`.
- `merged_source` out 8: to `upload_source_in`.
- `merged_valid` out 1: to `upload_valid_in`.
- `merged_ready` in 1: from `upload_ready_out`.
- `grant_idx` out $clog2(NUM_SRC) (min 1): currently or last granted source, for debug.
- `timeout_pulse` out 1: one-cycle pulse on forced release.

## Operation
- States: IDLE and GRANT. The grant index and the round-robin pointer are registers.
- **IDLE**
  - All merged outputs and all `src_ready` are 0.
  - Pick the first i with `src_req[i]`, searching from `(last+1) mod NUM_SRC` and wrapping.
  - If one is found: latch it into `grant_idx`, go to GRANT next cycle.
  - If none: stay in IDLE.
- **GRANT(g)**
  - `merged_req` = 1.
  - `merged_data`, `merged_source`, `merged_valid` = source g's fields.
  - `src_ready[g]` = `merged_ready`; every other `src_ready` bit = 0.
  - A byte transfers on a cycle where `src_valid[g]` & `merged_ready`.
- **Release from GRANT** (go to IDLE next cycle, set last := g) when either:
  - `src_req[g]` = 0 and no byte is pending. Pending means `src_valid[g]` & !`merged_ready`. A byte transferred in the same cycle as req falling counts as complete.
  - The watchdog reaches `TIMEOUT_CYC`. `timeout_pulse` = 1 in the releasing cycle. A pending byte is abandoned.
- **Watchdog:** a 16-bit counter.
  - Cleared on entry to GRANT and on every transfer.
  - Increments each GRANT cycle without a transfer.
  - Saturates; ignored in IDLE.
- **Packet boundary:** the mandatory IDLE cycle guarantees `merged_req` is low for at least 1 cycle between packets, even when the same source re-requests.
- **Non-granted sources:** request changes are ignored until the next IDLE arbitration.
- **Reset:** state IDLE, `grant_idx` 0, last = NUM_SRC-1 (first priority goes to source 0), counter 0, all outputs 0. Reset mid-packet drops the packet with no further handshakes.

## Timing
- Grant latency: req rises in cycle N (in IDLE) → `merged_req` = 1 in cycle N+1.
- Data path: combinational mux from the registered grant. Zero added latency; `src_ready` follows `merged_ready` in the same cycle.
- Release: the condition holds in cycle M → IDLE in M+1 with `merged_req` = 0 → earliest new grant in M+2.
- Throughput: one byte per cycle while granted.
- `timeout_pulse` is registered-state-qualified: it is high only in the GRANT cycle that triggers release.

## Structure
- Shared package holds:
  - source-index constants (`SRC_UART`=0, `SRC_SPI`=1);
  - upload source-ID byte values used by the handlers;
  - the IDLE/GRANT state encoding.
- One sub-module, `rr_picker`: combinational round-robin find-first over `NUM_SRC` with a pointer input; it outputs index and found flag.

## Test plan
1. **Single source:** SPI req, 4 bytes 0x11..0x14 with `merged_ready`=1 → `merged_req` rises 1 cycle after req; 4 bytes pass in order with source = SPI ID; IDLE the cycle after req drops.
2. **Simultaneous requests** from both sources after reset → UART (index 0) granted first, then SPI. A second round with both still requesting → SPI first, because last = 0.
3. **Backpressure:** `merged_ready` toggles 1,0,0,1 during a UART packet → `src_ready[0]` mirrors it exactly; `src_ready[1]` stays 0; no byte duplicated or lost.
4. **Req falls with byte pending:** `src_req` = 0 while valid=1 and ready=0 → grant held until ready=1 accepts the byte, then release.
5. **Watchdog:** with `TIMEOUT_CYC`=8, SPI holds req with no valid → `timeout_pulse` in the 9th GRANT cycle, then IDLE, then UART granted if requesting.
6. **Reset mid-packet:** assert `rst` after 2 of 5 bytes → all outputs 0 immediately; after deassert the next grant goes to source 0.
